// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder.
package nsa_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned NIBBLE = 4;

  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned steps;
    steps = width / NIBBLE;
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand (in_*) and result (out_*) valid/ready channels of the nibble-serial adder.
interface nibble_serial_adder_if #(parameter int unsigned WIDTH = 16);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/nibble_serial_adder_slice.sv
// Combinational 4-bit ripple-carry adder slice, iterated by the serial adder.
module nibble_add_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  always_comb begin
    logic [4:0] c;
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder computed one nibble per clock through a single 4-bit slice.
// Optional two's-complement overflow output enabled by defining NSA_OVERFLOW_EN.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  nibble_serial_adder_if.slave bus
);

  localparam int unsigned STEPS = WIDTH / NIBBLE;
  localparam int unsigned CW    = cnt_width(WIDTH);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_sh, b_sh, sum_sh, sum_ins;
  logic [CW-1:0]     cnt;
  logic              carry_q, cout_q;
  logic [NIBBLE-1:0] s;
  logic              co;
  logic              accept, last;

  nibble_add_slice u_slice (
    .a  (a_sh[NIBBLE-1:0]),
    .b  (b_sh[NIBBLE-1:0]),
    .ci (carry_q),
    .s  (s),
    .co (co)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: if (cnt == CW'(STEPS - 1)) begin
        last    = 1'b1;
        state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_sh;
  assign bus.cout      = cout_q;

  // New nibble enters at the top; after STEPS shifts nibble 0 lands at bit 0.
  assign sum_ins = WIDTH'(s) << (WIDTH - NIBBLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sh    <= bus.a;
      b_sh    <= bus.b;
      carry_q <= bus.cin;
      cnt     <= '0;
    end else if (state_q == RUN) begin
      a_sh    <= a_sh >> NIBBLE;
      b_sh    <= b_sh >> NIBBLE;
      sum_sh  <= (sum_sh >> NIBBLE) | sum_ins;
      carry_q <= co;
      cnt     <= cnt + 1'b1;
      if (last) cout_q <= co;
    end
  end

`ifdef NSA_OVERFLOW_EN
  logic ovf_q;

  // Carry into the MSB is recovered from the top nibble's operand and sum bits.
  always_ff @(posedge clk) begin
    if (rst)       ovf_q <= 1'b0;
    else if (last) ovf_q <= a_sh[NIBBLE-1] ^ b_sh[NIBBLE-1] ^ s[NIBBLE-1] ^ co;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: 16-bit and 4-bit instances against an arithmetic reference model.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer addition, overflow from operand/result signs.
  task automatic ref_add(input int unsigned w, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, output logic [15:0] s, output logic co, output logic ov);
    logic [16:0] full;
    logic [16:0] mask;
    logic        sa, sb, ss;
    mask = (17'd1 << w) - 17'd1;
    full = 17'(a) + 17'(b) + 17'(ci);
    s    = 16'(full & mask);
    co   = full[w];
    sa   = a[w-1];
    sb   = b[w-1];
    ss   = s[w-1];
`ifdef NSA_OVERFLOW_EN
    ov = (sa == sb) && (ss != sa);
`else
    ov = 1'b0;
`endif
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci, input string tag);
    logic [15:0] es;
    logic        ec, eo;
    int          edges;
    ref_add(16, a, b, ci, es, ec, eo);
    check({tag, " in_ready"}, 32'(bus16.in_ready), 32'd1);
    bus16.a = a; bus16.b = b; bus16.cin = ci; bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    check({tag, " busy"}, 32'({bus16.in_ready, bus16.out_valid}), 32'd0);
    edges = 0;
    while (!bus16.out_valid && edges < 50) begin
      step();
      edges++;
    end
    // 4 edges after the acceptance edge = 5 edges including it
    check({tag, " latency"}, 32'(edges), 32'd4);
    check({tag, " sum"},  32'(bus16.sum),  32'(es));
    check({tag, " cout"}, 32'(bus16.cout), 32'(ec));
    check({tag, " ovf"},  32'(bus16.ovf),  32'(eo));
    bus16.out_ready = 1'b1;
    step();
    bus16.out_ready = 1'b0;
    check({tag, " idle"}, 32'({bus16.in_ready, bus16.out_valid}), 32'b10);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci, input string tag);
    logic [15:0] es;
    logic        ec, eo;
    int          edges;
    ref_add(4, 16'(a), 16'(b), ci, es, ec, eo);
    bus4.a = a; bus4.b = b; bus4.cin = ci; bus4.in_valid = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    edges = 0;
    while (!bus4.out_valid && edges < 50) begin
      step();
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'd1);
    check({tag, " sum"},  32'(bus4.sum),  32'(es));
    check({tag, " cout"}, 32'(bus4.cout), 32'(ec));
    check({tag, " ovf"},  32'(bus4.ovf),  32'(eo));
    bus4.out_ready = 1'b1;
    step();
    bus4.out_ready = 1'b0;
    check({tag, " idle"}, 32'({bus4.in_ready, bus4.out_valid}), 32'b10);
  endtask

  initial begin
    logic [15:0] es;
    logic        ec, eo, seen;
    int          edges;

    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b0;
    bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0; bus4.out_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("rst16 hs",  32'({bus16.in_ready, bus16.out_valid}), 32'b10);
    check("rst16 sum", 32'(bus16.sum), 32'd0);
    check("rst16 c/o", 32'({bus16.cout, bus16.ovf}), 32'd0);
    check("rst4 hs",   32'({bus4.in_ready, bus4.out_valid}), 32'b10);
    check("rst4 sum",  32'(bus4.sum), 32'd0);

    op16(16'h1234, 16'h4321, 1'b0, "d1234");
    op16(16'hFFFF, 16'h0001, 1'b0, "ripple");
    op16(16'h7FFF, 16'h0001, 1'b0, "posovf");
    op16(16'h0000, 16'h0000, 1'b1, "cinonly");
    op16(16'h8000, 16'h8000, 1'b0, "negovf");

    // Stall in DONE while new operands are offered.
    ref_add(16, 16'hA5A5, 16'h5A5A, 1'b1, es, ec, eo);
    bus16.a = 16'hA5A5; bus16.b = 16'h5A5A; bus16.cin = 1'b1; bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    edges = 0;
    while (!bus16.out_valid && edges < 50) begin
      step();
      edges++;
    end
    check("stall reach", 32'(bus16.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus16.in_valid = 1'b1;
      bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'($urandom_range(0, 1));
      step();
      check("stall sum",  32'(bus16.sum), 32'(es));
      check("stall c/o",  32'({bus16.cout, bus16.ovf}), 32'({ec, eo}));
      check("stall hs",   32'({bus16.in_ready, bus16.out_valid}), 32'b01);
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    step();
    bus16.out_ready = 1'b0;
    check("stall exit", 32'({bus16.in_ready, bus16.out_valid}), 32'b10);
    step();
    step();
    check("stall noacc", 32'({bus16.in_ready, bus16.out_valid}), 32'b10);

    // Reset during RUN step 2: the operation must vanish.
    bus16.a = 16'h0F0F; bus16.b = 16'h1111; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst hs",  32'({bus16.in_ready, bus16.out_valid}), 32'b10);
    check("midrst sum", 32'(bus16.sum), 32'd0);
    check("midrst c/o", 32'({bus16.cout, bus16.ovf}), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | bus16.out_valid;
    end
    check("midrst quiet", 32'(seen), 32'd0);

    for (int i = 0; i < 20; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd16_%0d", i));

    op4(4'hF, 4'h1, 1'b0, "w4ripple");
    op4(4'h7, 4'h1, 1'b0, "w4ovf");
    for (int i = 0; i < 10; i++)
      op4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd4_%0d", i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
